// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, variable-latency imem handshake, held instruction with decode slices.
// Latency: ready -> instr_valid next cycle; commit -> new request next cycle. Stalls indefinitely in HOLD until commit.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        commit,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        instr_valid,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam int CW = (IMEM_TIMEOUT > 0) ? $clog2(IMEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (IMEM_TIMEOUT > 0) ? CW'(IMEM_TIMEOUT - 1) : '0;

  state_t        state, state_nxt;
  logic [31:0]   pc_q;
  logic [31:0]   instr_q;
  logic [31:0]   pc_plus4;
  logic [31:0]   next_pc;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;
  logic          next_misaligned;

  assign pc_plus4        = pc_q + 32'd4;
  assign next_pc         = PCSrc ? PCTarget : pc_plus4;
  assign next_misaligned = (next_pc[1:0] != 2'b00);
  // The current not-ready cycle is the last one allowed; counter never exceeds TIMEOUT-1.
  assign timeout_hit     = (IMEM_TIMEOUT != 0) && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          state_nxt = ST_HOLD;
        end else if (timeout_hit) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_HOLD: begin
        if (commit) begin
          state_nxt = next_misaligned ? ST_FAULT : ST_FETCH;
        end
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_fault = 1'b0;
    case (state)
      ST_FETCH: imem_req    = 1'b1;
      ST_HOLD:  instr_valid = 1'b1;
      ST_FAULT: fetch_fault = 1'b1;
      default:  ;
    endcase
  end

  // PC follows a misaligned commit too, so PC shows the faulting address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ready) begin
            instr_q  <= imem_rdata;
            wait_cnt <= '0;
          end else if (!timeout_hit) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          if (commit) begin
            pc_q     <= next_pc;
            wait_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign PC        = pc_q;
  assign PCPlus4   = pc_plus4;
  assign Instr     = instr_q;
  assign op        = instr_q[6:0];
  assign funct3    = instr_q[14:12];
  assign funct7b5  = instr_q[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, handshake latency, commit/branch, timeout, alignment, wrap.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        commit;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .commit(commit), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .instr_valid(instr_valid), .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
    .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    commit = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // From IDLE: one edge to FETCH, one with ready to HOLD carrying word w.
  task automatic fetch_into_hold(input logic [31:0] w);
    step();
    imem_ready = 1'b1; imem_rdata = w;
    step();
    imem_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      errors++; $display("FAIL reset_flags: req=%b vld=%b flt=%b want 0 0 0", imem_req, instr_valid, fetch_fault);
    end
    checks++;
    if (PC !== 32'h0 || Instr !== 32'h0 || PCPlus4 !== 32'h4) begin
      errors++; $display("FAIL reset_regs: PC=%h Instr=%h PCPlus4=%h want 0 0 4", PC, Instr, PCPlus4);
    end
  endtask

  task automatic test_first_fetch();
    imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL first_req: req=%b addr=%h vld=%b want 1 0 0", imem_req, imem_addr, instr_valid);
    end
    step();
    imem_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || Instr !== 32'h0050_0093) begin
      errors++; $display("FAIL first_hold: vld=%b req=%b Instr=%h want 1 0 00500093", instr_valid, imem_req, Instr);
    end
    checks++;
    if (op !== 7'h13 || funct3 !== 3'd0 || funct7b5 !== 1'b0) begin
      errors++; $display("FAIL first_decode: op=%h f3=%0d f7b5=%b want 13 0 0", op, funct3, funct7b5);
    end
  endtask

  task automatic test_commit();
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    PCSrc = 1'b1; PCTarget = 32'h0000_0800;
    step(); step();
    checks++;
    if (instr_valid !== 1'b1 || Instr !== 32'h0050_0093 || PC !== 32'h0) begin
      errors++; $display("FAIL hold_stable: vld=%b Instr=%h PC=%h want 1 00500093 0", instr_valid, Instr, PC);
    end
    imem_ready = 1'b0;
    commit = 1'b1; PCSrc = 1'b0;
    step();
    commit = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++; $display("FAIL commit_seq: req=%b addr=%h want 1 00000004", imem_req, imem_addr);
    end
    imem_ready = 1'b1; imem_rdata = 32'h4000_5033;
    step();
    imem_ready = 1'b0;
    checks++;
    if (op !== 7'h33 || funct3 !== 3'd5 || funct7b5 !== 1'b1 || PC !== 32'h4) begin
      errors++; $display("FAIL sra_decode: op=%h f3=%0d f7b5=%b PC=%h want 33 5 1 4", op, funct3, funct7b5, PC);
    end
    commit = 1'b1; PCSrc = 1'b1; PCTarget = 32'h0000_0100;
    step();
    commit = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || PC !== 32'h100 || PCPlus4 !== 32'h104) begin
      errors++; $display("FAIL branch: req=%b addr=%h PC=%h PCPlus4=%h want 1 100 100 104", imem_req, imem_addr, PC, PCPlus4);
    end
    imem_ready = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_ready = 1'b0;
  endtask

  task automatic test_delayed_ready();
    commit = 1'b1; PCSrc = 1'b0;
    step();
    commit = 1'b0;
    step(); step(); step();
    checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || fetch_fault !== 1'b0 || imem_addr !== 32'h104) begin
      errors++; $display("FAIL delay_wait: req=%b vld=%b flt=%b addr=%h want 1 0 0 104", imem_req, instr_valid, fetch_fault, imem_addr);
    end
    imem_ready = 1'b1; imem_rdata = 32'h0000_1063;
    step();
    imem_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || Instr !== 32'h0000_1063 || funct3 !== 3'd1) begin
      errors++; $display("FAIL delay_hold: vld=%b Instr=%h f3=%0d want 1 00001063 1", instr_valid, Instr, funct3);
    end
    // 14 not-ready cycles, ready on the 15th: only survives if the counter restarted.
    commit = 1'b1; PCSrc = 1'b0;
    step();
    commit = 1'b0;
    for (int i = 0; i < 14; i++) step();
    checks++;
    if (imem_req !== 1'b1 || fetch_fault !== 1'b0) begin
      errors++; $display("FAIL ready_at_limit_wait: req=%b flt=%b want 1 0", imem_req, fetch_fault);
    end
    imem_ready = 1'b1; imem_rdata = 32'h0000_0033;
    step();
    imem_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || fetch_fault !== 1'b0 || PC !== 32'h108) begin
      errors++; $display("FAIL ready_at_limit_hold: vld=%b flt=%b PC=%h want 1 0 108", instr_valid, fetch_fault, PC);
    end
  endtask

  task automatic test_timeout();
    int n;
    logic stuck;
    apply_reset();
    step();
    n = 0;
    while (imem_req === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++;
    if (n !== 15 || fetch_fault !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL timeout: fetch_cycles=%0d flt=%b req=%b want 15 1 0", n, fetch_fault, imem_req);
    end
    stuck = 1'b1;
    for (int i = 0; i < 6; i++) begin
      commit = i[0]; imem_ready = ~i[0]; imem_rdata = 32'h0000_0013;
      step();
      if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) stuck = 1'b0;
    end
    commit = 1'b0; imem_ready = 1'b0;
    checks++;
    if (stuck !== 1'b1) begin
      errors++; $display("FAIL fault_sticky: held=%b want 1", stuck);
    end
    apply_reset();
    checks++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL fault_clear: flt=%b req=%b want 0 0", fetch_fault, imem_req);
    end
  endtask

  task automatic test_misaligned();
    logic no_req;
    fetch_into_hold(32'h0000_0013);
    commit = 1'b1; PCSrc = 1'b1; PCTarget = 32'h0000_0102;
    step();
    commit = 1'b0;
    checks++;
    if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL misalign: flt=%b req=%b want 1 0", fetch_fault, imem_req);
    end
    no_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem_ready = 1'b1; commit = 1'b1;
      step();
      if (imem_req !== 1'b0 || fetch_fault !== 1'b1) no_req = 1'b0;
    end
    imem_ready = 1'b0; commit = 1'b0;
    checks++;
    if (no_req !== 1'b1) begin
      errors++; $display("FAIL misalign_noreq: quiet=%b want 1", no_req);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    fetch_into_hold(32'h0000_0013);
    commit = 1'b1; PCSrc = 1'b1; PCTarget = 32'h0000_0200;
    step();
    commit = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || PC !== 32'h0 || Instr !== 32'h0 || instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      errors++; $display("FAIL async_reset: req=%b PC=%h Instr=%h vld=%b flt=%b want 0 0 0 0 0", imem_req, PC, Instr, instr_valid, fetch_fault);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    fetch_into_hold(32'h0000_0013);
    commit = 1'b1; PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFC;
    step();
    commit = 1'b0;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin
      errors++; $display("FAIL wrap_plus4: addr=%h PCPlus4=%h want fffffffc 0", imem_addr, PCPlus4);
    end
    imem_ready = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_ready = 1'b0;
    commit = 1'b1; PCSrc = 1'b0;
    step();
    commit = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_fault !== 1'b0) begin
      errors++; $display("FAIL wrap_next: req=%b addr=%h flt=%b want 1 0 0", imem_req, imem_addr, fetch_fault);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_commit();
    test_delayed_ready();
    test_timeout();
    test_misaligned();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
